// File: rtl/cg_idle_ctrl_if.sv
// cg_idle_ctrl_if
//   Bundles the activity/wake handshake and the gate-enable outputs of the
//   idle clock-gating controller.
//   master : requester side; drives busy, wake_req and force_on, and observes
//            gate_en, wake_ack, gated and state.
//   slave  : the controller; consumes the requests and drives the outputs.
//   Signals:
//     busy     - downstream activity, 1 = not idle
//     wake_req - level request for the clock, held until wake_ack
//     force_on - override, never gate while high
//     gate_en  - enable to the clock-gating cell (flop output)
//     wake_ack - level acknowledge, clock is on and stable
//     gated    - 1 while the clock is gated
//     state    - FSM state (RUN=0, IDLE_WAIT=1, GATED=2, WAKE=3)
interface cg_idle_ctrl_if;
  logic       busy;
  logic       wake_req;
  logic       force_on;
  logic       gate_en;
  logic       wake_ack;
  logic       gated;
  logic [1:0] state;

  modport master (
    output busy, wake_req, force_on,
    input  gate_en, wake_ack, gated, state
  );

  modport slave (
    input  busy, wake_req, force_on,
    output gate_en, wake_ack, gated, state
  );
endinterface

// File: rtl/cg_idle_ctrl.sv
// cg_idle_ctrl
//   Enable generator for a safe clock-gating cell. Counts consecutive idle
//   cycles and drops gate_en after IDLE_CYCLES of them; restores the clock on
//   any activity or wake request and acknowledges wake_req once the clock has
//   run for WAKE_CYCLES. Runs on the free-running clock.
//   Ports:
//     clk   - free-running clock, rising-edge
//     rst_n - synchronous active-low reset (clock on after reset)
//     bus   - cg_idle_ctrl_if.slave: busy/wake_req/force_on in,
//             gate_en/wake_ack/gated/state out
module cg_idle_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cg_idle_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_en_q, gate_en_d;
  logic             gated_q, gated_d;
  logic             wake_ack_q, wake_ack_d;
  logic             idle;

  // A held wake request counts as activity, so it always keeps the clock on.
  assign idle = !bus.busy && !bus.wake_req && !bus.force_on;

  // State register; outputs are registered too so nothing reaches the gating
  // cell combinationally from the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      gate_en_q  <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_en_q  <= gate_en_d;
      gated_q    <= gated_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  // Next-state and shared idle/wake counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (idle) begin
          state_d = IDLE_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      IDLE_WAIT: begin
        if (!idle) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = GATED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      GATED: begin
        if (!idle) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        // Inputs are ignored here: the settle period always runs in full.
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the transition so
  // gate_en rises on the same edge that leaves GATED.
  always_comb begin
    gate_en_d  = (state_d != GATED);
    gated_d    = (state_d == GATED);
    wake_ack_d = 1'b0;
    if (state_q == RUN || state_q == IDLE_WAIT ||
        (state_q == WAKE && state_d == RUN)) begin
      wake_ack_d = bus.wake_req;
    end
  end

  assign bus.gate_en  = gate_en_q;
  assign bus.gated    = gated_q;
  assign bus.wake_ack = wake_ack_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_cg_idle_ctrl.sv
// tb_cg_idle_ctrl
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model of the gating rules.
module tb_cg_idle_ctrl;
  localparam int IDLE_CYCLES = 8;
  localparam int WAKE_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cg_idle_ctrl_if bus ();

  cg_idle_ctrl #(
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: is the clock gated, how many consecutive idle edges have been
  // seen with the clock on, and how many settle edges remain after a wake.
  bit m_gated    = 1'b0;
  int m_idle_run = 0;
  int m_wake_rem = 0;
  bit m_ack      = 1'b0;
  int m_state    = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_edge(input bit r, input bit b, input bit w, input bit f);
    bit active;
    active = b || w || f;
    if (!r) begin
      m_gated = 0; m_idle_run = 0; m_wake_rem = 0; m_ack = 0; m_state = 0;
    end else if (m_gated) begin
      m_ack = 0;
      if (active) begin
        m_gated = 0; m_wake_rem = WAKE_CYCLES; m_state = 3;
      end
    end else if (m_wake_rem > 0) begin
      m_wake_rem--;
      m_ack = 0;
      if (m_wake_rem == 0) begin
        m_state = 0; m_ack = w; m_idle_run = 0;
      end
    end else begin
      m_ack = w;
      if (active) begin
        m_idle_run = 0; m_state = 0;
      end else begin
        m_idle_run++;
        if (m_idle_run == IDLE_CYCLES) begin
          m_gated = 1; m_idle_run = 0; m_state = 2;
        end else begin
          m_state = 1;
        end
      end
    end
  endtask

  // One clock: drive inputs, take the edge, update model, compare.
  task automatic step(input bit r, input bit b, input bit w, input bit f);
    rst_n        = r;
    bus.busy     = b;
    bus.wake_req = w;
    bus.force_on = f;
    @(posedge clk);
    model_edge(r, b, w, f);
    #1;
    chk("gate_en",  8'(bus.gate_en),  8'(!m_gated));
    chk("gated",    8'(bus.gated),    8'(m_gated));
    chk("wake_ack", 8'(bus.wake_ack), 8'(m_ack));
    chk("state",    8'(bus.state),    8'(m_state));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    bit wh;
    int pb, pw, pf;
    rst_n = 1'b0; bus.busy = 1'b0; bus.wake_req = 1'b0; bus.force_on = 1'b0;
    @(negedge clk);

    // Reset with random inputs.
    for (int i = 0; i < 2; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom));

    // Idle gating: gated after the 8th idle edge, not before.
    idle_n(IDLE_CYCLES + 2);

    // Wake from GATED, handshake, drop, re-gate.
    step(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    idle_n(IDLE_CYCLES + 1);
    step(1, 1, 0, 0);                       // busy while gated acts as a wake
    idle_n(3);
    step(1, 0, 1, 0); step(1, 0, 1, 0);     // request while clock already on
    step(1, 0, 0, 0);

    // Idle interruption.
    idle_n(5);
    step(1, 1, 0, 0);
    idle_n(IDLE_CYCLES + 1);

    // Override.
    step(1, 0, 1, 0); idle_n(3);
    for (int i = 0; i < 20; i++) step(1, 1'($urandom), 0, 1);
    idle_n(IDLE_CYCLES + 1);

    // Reset mid-operation in GATED, then in WAKE with wake_req held.
    step(0, 0, 0, 0);
    idle_n(IDLE_CYCLES);
    step(1, 0, 1, 0);                       // GATED -> WAKE
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);

    // Randomized traffic, with the requester following the handshake.
    wh = 0; pb = 5; pw = 2; pf = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(3))
          0: begin pb = 0;  pw = 0; pf = 0; end
          1: begin pb = 5;  pw = 2; pf = 1; end
          2: begin pb = 30; pw = 5; pf = 0; end
          default: begin pb = 2; pw = 10; pf = 3; end
        endcase
      end
      if (wh && m_ack && $urandom_range(3) == 0) wh = 0;
      else if (!wh && $urandom_range(99) < pw) wh = 1;
      step(!($urandom_range(199) == 0),
           $urandom_range(99) < pb,
           wh,
           $urandom_range(99) < pf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cg_idle_ctrl.md
Name: cg_idle_ctrl

Overview:
- Enable generator for the safe clock-gating cell: it produces the `en` input that the gate consumes.
- Watches downstream activity and counts consecutive idle cycles. After a programmable idle window it drops the gate enable.
- Restores the clock on a wake request and acknowledges the requester with a level handshake once the clock has been stable for a settle period.
- Runs on the free-running (ungated) clock next to the gating cell.

Parameters:
- IDLE_CYCLES, 8: consecutive idle cycles required before gating. Legal range 2..2**CNT_W.
- WAKE_CYCLES, 2: cycles the clock runs in WAKE before the acknowledge. Legal range 1..2**CNT_W.
- CNT_W, 4: width of the shared idle/wake counter.

Ports:
- clk, input, 1: free-running clock; all state updates on its rising edge.
- rst_n, input, 1: reset.
- busy, input, 1: downstream activity (e.g. data valid); 1 = not idle.
- wake_req, input, 1: level request for the clock. Held high until wake_ack is seen, then dropped.
- force_on, input, 1: override; while high the block never gates.
- gate_en, output, 1: enable to the clock-gating cell. Driven directly from a flop.
- wake_ack, output, 1: level acknowledge; clock is on and stable.
- gated, output, 1: status; 1 while the clock is gated.
- state, output, 2: FSM state. RUN=0, IDLE_WAIT=1, GATED=2, WAKE=3.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=RUN, gate_en=1, gated=0, wake_ack=0, counter=0.
  - Reset fails safe: clock on.
  - rst_n is sampled only on a clk edge, so a reset asserted mid-operation, including in GATED or WAKE, takes effect at the next edge.
- Definition: idle = !busy && !wake_req && !force_on.
- RUN (gate_en=1, gated=0):
  - If idle: go to IDLE_WAIT, counter<=1.
  - Otherwise stay, counter<=0.
- IDLE_WAIT (gate_en=1, gated=0):
  - If !idle: go to RUN, counter<=0.
  - Else if counter==IDLE_CYCLES-1: go to GATED, counter<=0.
  - Else counter<=counter+1.
  - Net effect: gate_en goes low after the IDLE_CYCLES-th consecutive idle edge. Any non-idle cycle restarts the full window.
- GATED (gate_en=0, gated=1):
  - If busy, wake_req or force_on is high: go to WAKE, counter<=0. gate_en returns to 1 at that same edge.
  - Busy arriving while gated is treated as a wake.
- WAKE (gate_en=1, gated=0):
  - counter increments each cycle.
  - When counter==WAKE_CYCLES-1: go to RUN, counter<=0.
  - Inputs are ignored until the WAKE period completes; WAKE always runs its full length.
- wake_ack is registered:
  - In RUN and IDLE_WAIT: wake_ack<=wake_req.
  - In GATED and WAKE: wake_ack<=0.
  - On the WAKE->RUN edge: wake_ack<=wake_req.
  - Result: a request made while the clock is already on is acked one edge later. wake_ack deasserts one edge after wake_req falls.
- Because wake_req is part of the idle term, a held request always keeps the clock on.
- Simultaneous events:
  - force_on, busy and wake_req all have equal effect on gating.
  - No input can lower gate_en except through a completed IDLE_WAIT window.
- Glitch-freedom:
  - gate_en, gated and wake_ack are flop outputs with no combinational path from inputs.
  - gate_en changes only at rising clk edges; the gating cell latches it on the low phase.
- Counter never exceeds max(IDLE_CYCLES, WAKE_CYCLES)-1. No wrap-around is possible for legal parameters.

Test Plan (IDLE_CYCLES=8, WAKE_CYCLES=2):
- Reset: rst_n=0 for 2 edges with all inputs random -> gate_en=1, gated=0, wake_ack=0, state=0 after the first low-sampled edge.
- Idle gating: after reset, busy=wake_req=force_on=0 -> state=1 after edge 1; gate_en=0, gated=1, state=2 after edge 8, not before.
- Idle interruption: 5 idle cycles, then busy=1 for 1 cycle, then idle -> state back to 0, gate_en stays 1; gating occurs only 8 idle edges after busy drops (13+ total).
- Wake handshake: in GATED raise wake_req=1 -> gate_en=1 and state=3 next edge; state=0 with wake_ack=1 two edges later. Drop wake_req -> wake_ack=0 next edge; gate_en=0 again 8 idle edges later. A second wake_req raised while in RUN is acked after 1 edge.
- Override: force_on=1 held 20 cycles -> gate_en never 0, state toggles only within RUN. Release -> gate_en=0 exactly 8 edges later.
- Reset mid-operation: rst_n=0 for 1 edge while in GATED (and separately while in WAKE) -> gate_en=1, state=0, wake_ack=0 after that edge. A wake_req held through reset gets wake_ack one edge after rst_n returns high.
